dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
Controller for the MEM stage. It sits between the EX/MEM pipeline register outputs and a request/acknowledge data-memory bus. It sequences each load or store into a single bus transaction, generates byte enables, aligns store data and sign/zero-extends load data. It holds `stall` to freeze the pipeline until the access completes, times out, or is rejected as illegal.

Parameters:
- TIMEOUT_CYCLES, 256: maximum BUSY cycles without `bus_ack` before the access is aborted. 0 disables the timeout.
- CNT_W, 9: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  load in MEM stage (from EX/MEM register).
- mem_write  in  1  store in MEM stage.
- mask  in  3  funct3 access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  byte address (EX/MEM ALU result).
- wdata  in  32  store data (EX/MEM write data).
- bus_req  out  1  transaction request, registered.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, {addr[31:2], 2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  transaction complete. `bus_rdata` is valid in the same cycle.
- bus_rdata  in  32  read word.
- load_data  out  32  extended load result, registered.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- access_err  out  1  illegal or misaligned access, level.
- timeout_err  out  1  one-cycle pulse on abort.

Behaviour:
- Clock/reset: one clock domain. reset_n is asynchronous and active-low. On reset assertion:
  - state goes to IDLE.
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata, load_data, timeout_err and the counter all go to 0.
  - bus_req drops immediately, including mid-transaction. A pending ack after reset is ignored.
- Access detection:
  - access = mem_read | mem_write.
  - If both are high, the access is treated as a write.
- Illegal access. Any of the following is illegal:
  - mask ∈ {011, 110, 111};
  - mask 1x1 on a store;
  - halfword with addr[0] = 1;
  - word with addr[1:0] ≠ 00.
- States:
  - IDLE:
    - access legal: stall = 1 (combinational). Latch bus_addr, bus_be, bus_wdata, bus_we and the mask/lane. Set bus_req = 1 and go to BUSY.
    - access illegal: access_err = 1, stall = 0, no bus activity, stay in IDLE.
    - no access: stall = 0.
  - BUSY: stall = 1. bus_req and all bus_* outputs are held stable.
    - bus_ack: drop bus_req. For a read, load_data <= extend(bus_rdata). Go to DONE.
    - else, if TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES: drop bus_req, pulse timeout_err, load_data <= 0, go to DONE.
    - The counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - DONE: stall = 0. The pipeline advances at the end of this cycle, and the same instruction is still on the inputs, so no new request is started. Go to IDLE unconditionally.
- Latency and ack handling:
  - Best case is 3 cycles per access (IDLE, BUSY with ack, DONE).
  - Minimum 2 stall cycles.
  - bus_ack outside BUSY is ignored.
- Store formatting (lane = addr[1:0]):
  - SB: bus_wdata = {4{wdata[7:0]}}, bus_be = 0001 << lane.
  - SH: bus_wdata = {2{wdata[15:0]}}, bus_be = 0011 << lane.
  - SW: bus_wdata = wdata, bus_be = 1111.
- Load formatting:
  - bus_be = 1111 for all reads.
  - The selected byte or halfword is the one at the lane.
  - 000/001: sign-extend. 100/101: zero-extend. 010: full word.
- load_data holds its value between loads and is not changed by stores or errors (except the timeout write of 0).

Test Plan:
- LW, addr 0x1000_0008, ack after 2 BUSY cycles, rdata 0xDEAD_BEEF.
  -> bus_addr 0x1000_0008, be 1111, stall high for 3 cycles, load_data 0xDEAD_BEEF in the DONE cycle.
- LB at addr 0x…03 with rdata 0x80_12_34_56 -> load_data 0xFFFF_FF80.
  LBU at the same address -> 0x0000_0080.
  LHU at addr 0x…02 -> 0x0000_8012.
- SH at addr 0x…02, wdata 0x1234_ABCD, immediate ack.
  -> bus_we 1, be 1100, bus_wdata 0xABCD_ABCD, load_data unchanged.
- LW at addr 0x…01, and separately mask 011.
  -> access_err 1, stall 0, bus_req never asserted, state stays IDLE.
- TIMEOUT_CYCLES = 4, no ack.
  -> bus_req high for 4 BUSY cycles, then timeout_err pulses once, load_data 0, stall released in DONE.
- Reset mid-BUSY, then ack arrives.
  -> bus_req 0 asynchronously, stall 0, ack ignored. The next LW completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access controller: turns one load/store into a single
// req/ack bus transaction, formats store lanes, extends load data, and stalls the pipeline.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        access_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W:0] TMO_LIMIT = (CNT_W+1)'(TIMEOUT_CYCLES);

    state_e state_q, state_d;

    logic             bus_req_q, bus_we_q, timeout_err_q;
    logic [31:0]      bus_addr_q, bus_wdata_q, load_data_q;
    logic [3:0]       bus_be_q;
    logic [2:0]       mask_q;
    logic [1:0]       lane_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_next;

    logic        access, is_write, illegal, start, timeout_hit;
    logic [1:0]  lane;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt, load_ext;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign access   = mem_read | mem_write;
    assign is_write = mem_write;
    assign lane     = addr[1:0];
    assign start    = (state_q == IDLE) && access && !illegal;
    assign cnt_next = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // A zero limit disables the abort entirely.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == BUSY) && !bus_ack
                         && (cnt_next == TMO_LIMIT);

    always_comb begin
        illegal = 1'b0;
        case (mask)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            default: ;
        endcase
        if (is_write && mask[2] && mask[0])
            illegal = 1'b1;
        if ((mask[1:0] == 2'b01) && addr[0])
            illegal = 1'b1;
        if ((mask[1:0] == 2'b10) && (addr[1:0] != 2'b00))
            illegal = 1'b1;
    end

    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = wdata;
        if (is_write) begin
            case (mask[1:0])
                2'b00: begin
                    be_fmt    = 4'b0001 << lane;
                    wdata_fmt = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_fmt    = 4'b0011 << lane;
                    wdata_fmt = {2{wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Lane selection uses the latched address so inputs may change during BUSY.
    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = bus_rdata[7:0];
            2'd1:    rd_byte = bus_rdata[15:8];
            2'd2:    rd_byte = bus_rdata[23:16];
            default: rd_byte = bus_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (mask_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_ext = {24'd0, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_ext = {16'd0, rd_half};
            default: load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (bus_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        access_err = 1'b0;
        case (state_q)
            IDLE: begin
                stall      = start;
                access_err = access && illegal;
            end
            BUSY:    stall = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= '0;
            bus_wdata_q   <= '0;
            mask_q        <= '0;
            lane_q        <= '0;
            load_data_q   <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            timeout_err_q <= timeout_hit;
            if (start) begin
                bus_req_q   <= 1'b1;
                bus_we_q    <= is_write;
                bus_addr_q  <= {addr[31:2], 2'b00};
                bus_be_q    <= be_fmt;
                bus_wdata_q <= wdata_fmt;
                mask_q      <= mask;
                lane_q      <= lane;
                cnt_q       <= '0;
            end else if (state_q == BUSY) begin
                if (bus_ack) begin
                    bus_req_q <= 1'b0;
                    if (!bus_we_q)
                        load_data_q <= load_ext;
                end else if (timeout_hit) begin
                    bus_req_q   <= 1'b0;
                    load_data_q <= '0;
                end else begin
                    cnt_q <= cnt_next[CNT_W-1:0];
                end
            end
        end
    end

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;
    assign load_data   = load_data_q;
    assign timeout_err = timeout_err_q;

endmodule
